// File: rtl/pe_col_ctrl.sv
// Column sequencer: loads weights/acts into NPE PEs, starts the 1D conv, drives the psum chain
// and returns NOUT column sums; all outputs registered, no backpressure on the sum stream.
module pe_col_ctrl #(
  parameter int NPE    = 3,
  parameter int PSUM_W = 20,
  parameter int MAXA   = 16,
  localparam int PW    = (NPE > 1) ? $clog2(NPE) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [7:0]        cfg_acount,
  input  logic [7:0]        cfg_wcount,
  output logic [7:0]        pe_acount,
  output logic [7:0]        pe_wcount,
  output logic [NPE-1:0]    pe_loadw,
  output logic [NPE-1:0]    pe_loada,
  output logic              pe_start,
  output logic              pe_sums,
  input  logic [NPE-1:0]    pe_done,
  output logic              ld_req,
  output logic              ld_kind,
  output logic [PW-1:0]     ld_pe,
  output logic [7:0]        ld_idx,
  input  logic [PSUM_W-1:0] psum_top,
  output logic              sum_valid,
  output logic [PSUM_W-1:0] sum_data,
  output logic [7:0]        sum_idx,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LOADW, LOADA, START, COMPUTE, SUMS, DRAIN} state_t;

  state_t         state_q;
  logic [PW-1:0]  pe_q;
  logic [15:0]    cnt_q;
  logic [NPE-1:0] tap_q;
  logic [7:0]     sidx_q;

  logic [15:0] nout_d, comp_d, len_d;
  logic        bad_d;

  always_comb begin
    nout_d = {8'd0, pe_acount} + 16'd2 - {8'd0, pe_wcount};
    comp_d = nout_d * {8'd0, pe_wcount} + 16'd2;
    len_d  = (state_q == LOADW) ? {8'd0, pe_wcount} : {8'd0, pe_acount};
    bad_d  = (cfg_wcount == 8'd0) || (cfg_wcount > cfg_acount) || (cfg_acount > 8'(MAXA));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      pe_q      <= '0;
      cnt_q     <= '0;
      tap_q     <= '0;
      sidx_q    <= '0;
      cfg_ready <= 1'b1;
      pe_acount <= '0;
      pe_wcount <= '0;
      pe_loadw  <= '0;
      pe_loada  <= '0;
      pe_start  <= 1'b0;
      pe_sums   <= 1'b0;
      ld_req    <= 1'b0;
      ld_kind   <= 1'b0;
      ld_pe     <= '0;
      ld_idx    <= '0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
      sum_idx   <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      pe_loadw <= '0;
      pe_loada <= '0;
      pe_start <= 1'b0;

      // pe_sums travels NPE cycles up the chain; the tap tells us which psum_top cycle to capture
      tap_q     <= {tap_q[NPE-2:0], pe_sums};
      sum_valid <= tap_q[NPE-1];
      if (tap_q[NPE-1]) begin
        sum_data <= psum_top;
        sum_idx  <= sidx_q;
        sidx_q   <= sidx_q + 8'd1;
      end

      case (state_q)
        IDLE: begin
          if (cfg_valid && cfg_ready) begin
            pe_acount <= cfg_acount;
            pe_wcount <= cfg_wcount;
            err       <= bad_d;
            if (!bad_d) begin
              state_q   <= LOADW;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
              pe_q      <= '0;
              cnt_q     <= '0;
              sidx_q    <= '0;
              pe_loadw  <= NPE'(1);
              ld_req    <= 1'b1;
              ld_kind   <= 1'b0;
              ld_pe     <= '0;
              ld_idx    <= '0;
            end
          end
        end
        LOADW, LOADA: begin
          if (cnt_q == len_d) begin
            // gap cycle: advance to the next PE or the next phase
            cnt_q <= '0;
            if (pe_q == PW'(NPE - 1)) begin
              pe_q <= '0;
              if (state_q == LOADW) begin
                state_q  <= LOADA;
                pe_loada <= NPE'(1);
                ld_req   <= 1'b1;
                ld_kind  <= 1'b1;
                ld_pe    <= '0;
                ld_idx   <= '0;
              end else begin
                state_q  <= START;
                pe_start <= 1'b1;
              end
            end else begin
              pe_q   <= pe_q + 1'b1;
              ld_req <= 1'b1;
              ld_pe  <= pe_q + 1'b1;
              ld_idx <= '0;
              if (state_q == LOADW) pe_loadw <= NPE'(1) << (pe_q + 1'b1);
              else                  pe_loada <= NPE'(1) << (pe_q + 1'b1);
            end
          end else begin
            cnt_q  <= cnt_q + 16'd1;
            ld_req <= (cnt_q + 16'd1) < len_d;
            ld_idx <= 8'(cnt_q + 16'd1);
          end
        end
        START: begin
          state_q <= COMPUTE;
          cnt_q   <= '0;
        end
        COMPUTE: begin
          if (cnt_q == comp_d - 16'd1) begin
            if (pe_done != '1) err <= 1'b1;
            state_q <= SUMS;
            pe_sums <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SUMS: begin
          if (cnt_q == nout_d - 16'd1) begin
            pe_sums <= 1'b0;
            state_q <= DRAIN;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DRAIN: begin
          if (sum_valid && sum_idx == nout_d[7:0] - 8'd1) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_col_ctrl.sv
// Bench for pe_col_ctrl: job table replayed cycle by cycle against a timeline model,
// plus a mid-load reset sequence.
module tb_pe_col_ctrl;
  localparam int NPE = 3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cfg_valid, cfg_ready;
  logic [7:0]  cfg_acount, cfg_wcount, pe_acount, pe_wcount;
  logic [2:0]  pe_loadw, pe_loada, pe_done;
  logic        pe_start, pe_sums, ld_req, ld_kind;
  logic [1:0]  ld_pe;
  logic [7:0]  ld_idx, sum_idx;
  logic [19:0] psum_top, sum_data;
  logic        sum_valid, busy, err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pe_col_ctrl #(.NPE(3), .PSUM_W(20), .MAXA(16)) dut (
    .clk(clk), .nrst(nrst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_acount(cfg_acount), .cfg_wcount(cfg_wcount),
    .pe_acount(pe_acount), .pe_wcount(pe_wcount),
    .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
    .pe_done(pe_done), .ld_req(ld_req), .ld_kind(ld_kind), .ld_pe(ld_pe), .ld_idx(ld_idx),
    .psum_top(psum_top), .sum_valid(sum_valid), .sum_data(sum_data), .sum_idx(sum_idx),
    .busy(busy), .err(err)
  );

  typedef struct packed {
    logic        cfg_ready, busy, err;
    logic [2:0]  loadw, loada;
    logic        start, sums, ld_req, ld_kind;
    logic [1:0]  ld_pe;
    logic [7:0]  ld_idx;
    logic        sum_valid;
    logic [19:0] sum_data;
    logic [7:0]  sum_idx, acount, wcount;
  } outv_t;

  typedef struct {
    int a; int w; bit done; bit hold; int stop;  // inputs
    bit exp_err; int exp_nout;                    // hand-computed expectations
  } job_t;

  // Column sum of a zero-padded 1D conv over NPE PEs with known per-PE weights/acts.
  function automatic int model(int a, int w, int j);
    int s = 0;
    for (int p = 0; p < NPE; p++)
      for (int k = 0; k < w; k++) begin
        int idx = j + k - 1;
        if (idx >= 0 && idx < a) s += (p + k + 1) * (3 * p + idx + 2);
      end
    return s;
  endfunction

  task automatic check(input int id, input int r, input outv_t e);
    outv_t g;
    g = '{cfg_ready, busy, err, pe_loadw, pe_loada, pe_start, pe_sums, ld_req, ld_kind,
          ld_pe, ld_idx, sum_valid, sum_data, sum_idx, pe_acount, pe_wcount};
    if (!e.ld_req) begin g.ld_kind = 1'b0; g.ld_pe = '0; g.ld_idx = '0; end
    if (!e.sum_valid) begin g.sum_data = '0; g.sum_idx = '0; end
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL job%0d cycle %0d: got %h required %h", id, r, g, e);
    end
  endtask

  task automatic run_job(input int id, input job_t jb);
    int a = jb.a, w = jb.w, nout = jb.exp_nout;
    int s_cyc = NPE * (w + 1) + NPE * (a + 1);
    int u_cyc = s_cyc + 1 + nout * w + 2;
    int l_cyc = u_cyc + nout + NPE;
    int last;
    outv_t e;
    cfg_acount = 8'(a);
    cfg_wcount = 8'(w);
    cfg_valid  = 1'b1;
    pe_done    = jb.done ? 3'b111 : 3'b000;
    @(posedge clk); #1;
    if (!jb.hold) cfg_valid = 1'b0;
    last = jb.exp_err ? 3 : (jb.stop >= 0 ? jb.stop : l_cyc + 1);
    for (int r = 0; r <= last; r++) begin
      if (!jb.exp_err && r >= u_cyc + NPE && r < u_cyc + NPE + nout)
        psum_top = 20'(model(a, w, r - u_cyc - NPE));
      else
        psum_top = 20'h5A5A5;
      @(negedge clk);
      e = '0;
      e.acount = 8'(a);
      e.wcount = 8'(w);
      if (jb.exp_err) begin
        e.cfg_ready = 1'b1;
        e.err = 1'b1;
      end else begin
        e.busy = (r <= l_cyc);
        e.cfg_ready = !e.busy;
        e.err = (r >= u_cyc) && !jb.done;
        if (r < NPE * (w + 1)) begin
          int p = r / (w + 1), q = r % (w + 1);
          if (q == 0) e.loadw = 3'(1 << p);
          if (q < w) begin e.ld_req = 1'b1; e.ld_pe = 2'(p); e.ld_idx = 8'(q); end
        end else if (r < s_cyc) begin
          int rr = r - NPE * (w + 1);
          int p = rr / (a + 1), q = rr % (a + 1);
          if (q == 0) e.loada = 3'(1 << p);
          if (q < a) begin e.ld_req = 1'b1; e.ld_kind = 1'b1; e.ld_pe = 2'(p); e.ld_idx = 8'(q); end
        end
        e.start = (r == s_cyc);
        e.sums  = (r >= u_cyc) && (r < u_cyc + nout);
        if (r >= u_cyc + NPE + 1 && r < u_cyc + NPE + 1 + nout) begin
          e.sum_valid = 1'b1;
          e.sum_idx   = 8'(r - u_cyc - NPE - 1);
          e.sum_data  = 20'(model(a, w, r - u_cyc - NPE - 1));
        end
      end
      check(id, r, e);
      if (r < last) begin @(posedge clk); #1; end
    end
  endtask

  job_t jobs[9];
  outv_t idle_e;

  initial begin
    //           a   w  done hold stop  err nout
    jobs[0] = '{ 5,  3, 1'b1, 1'b0, -1, 1'b0, 4};
    jobs[1] = '{ 3,  4, 1'b1, 1'b0, -1, 1'b1, 0};
    jobs[2] = '{ 4,  2, 1'b1, 1'b0, -1, 1'b0, 4};
    jobs[3] = '{ 5,  3, 1'b0, 1'b0, -1, 1'b0, 4};
    jobs[4] = '{ 1,  1, 1'b1, 1'b1, -1, 1'b0, 2};
    jobs[5] = '{16, 16, 1'b1, 1'b0, -1, 1'b0, 2};
    jobs[6] = '{17,  3, 1'b1, 1'b0, -1, 1'b1, 0};
    jobs[7] = '{ 2,  0, 1'b1, 1'b0, -1, 1'b1, 0};
    jobs[8] = '{ 7,  1, 1'b1, 1'b0, -1, 1'b0, 8};

    cfg_valid  = 1'b0;
    cfg_acount = '0;
    cfg_wcount = '0;
    pe_done    = '0;
    psum_top   = '0;
    idle_e = '0;
    idle_e.cfg_ready = 1'b1;

    #12;
    check(100, 0, idle_e);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    check(101, 0, idle_e);

    for (int i = 0; i < 9; i++) run_job(i, jobs[i]);
    cfg_valid = 1'b0;

    // Reset partway through the activation load, then run a clean job.
    run_job(200, '{5, 3, 1'b1, 1'b0, 15, 1'b0, 4});
    nrst = 1'b0;
    #1;
    check(201, 0, idle_e);
    @(posedge clk); #1;
    check(202, 1, idle_e);
    nrst = 1'b1;
    @(negedge clk);
    check(203, 2, idle_e);
    run_job(204, '{5, 3, 1'b1, 1'b0, -1, 1'b0, 4});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
